// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl
// Byte-level register controller sitting behind i2c_slave. It turns the
// slave's wr/rd/ready byte handshake into pointer-addressed accesses to a
// small internal register file. A local requester shares the same register
// file through a fixed-priority arbiter, where I2C events always win.
//
// Build option:
//   I2C_REG_AUTOINC_EN  when defined, the pointer advances by one after every
//                       I2C data write and every I2C read. When undefined, the
//                       pointer changes only on pointer-byte writes.
//
// Ports:
//   sys_clk, rst              system clock, synchronous active-high reset
//   i2c_wr, i2c_rx_data       written-byte strobe (level) and its data
//   i2c_rd                    read request (level, held until i2c_ready)
//   i2c_tx_data, i2c_ready    read data and one-cycle ready pulse
//   loc_req, loc_we, loc_addr, loc_wdata
//                             local access request
//   loc_gnt, loc_rdata        local grant pulse and read data
//   wr_evt, wr_evt_addr       pulse plus address for each committed I2C write
//
// state  | meaning
// IDLE   | arbitrate I2C wr, I2C rd, then local request
// WRITE  | pointer or data byte committed; wr_evt visible here
// RFETCH | read reg[ptr] into i2c_tx_data
// RRESP  | i2c_ready high for this cycle only
// LOCAL  | local access performed; loc_gnt visible here
module i2c_reg_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              i2c_wr,
  input  logic [7:0]        i2c_rx_data,
  input  logic              i2c_rd,
  output logic [7:0]        i2c_tx_data,
  output logic              i2c_ready,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic              loc_gnt,
  output logic [7:0]        loc_rdata,
  output logic              wr_evt,
  output logic [ADDR_W-1:0] wr_evt_addr
);

  localparam int          DEPTH       = 1 << ADDR_W;
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, WRITE, RFETCH, RRESP, LOCAL} state_t;

  state_t            state;
  logic              wr_q, rd_q;
  logic              wr_pend, rd_pend;
  logic              ptr_phase;
  logic [ADDR_W-1:0] ptr;
  logic [15:0]       idle_cnt;
  logic [7:0]        regs [DEPTH];

  logic wr_ev, rd_ev;
  assign wr_ev = i2c_wr & ~wr_q;
  assign rd_ev = i2c_rd & ~rd_q;

  // The write itself is committed on the IDLE->WRITE edge so that the
  // register, pointer and wr_evt are all visible in the cycle after the
  // wr edge. Likewise a local access is performed on the IDLE->LOCAL edge.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      ptr_phase   <= 1'b1;
      ptr         <= '0;
      idle_cnt    <= 16'd0;
      i2c_tx_data <= 8'h00;
      i2c_ready   <= 1'b0;
      loc_gnt     <= 1'b0;
      loc_rdata   <= 8'h00;
      wr_evt      <= 1'b0;
      wr_evt_addr <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      wr_q      <= i2c_wr;
      rd_q      <= i2c_rd;
      i2c_ready <= 1'b0;
      loc_gnt   <= 1'b0;
      wr_evt    <= 1'b0;

      if (wr_ev || rd_ev)
        idle_cnt <= 16'd0;
      else if (idle_cnt != 16'hFFFF)
        idle_cnt <= idle_cnt + 16'd1;

      // Bus went quiet long enough: the next written byte restarts as a pointer.
      // FSM assignments below take precedence in the same cycle.
      if (idle_cnt == TIMEOUT_VAL)
        ptr_phase <= 1'b1;

      // Edges not consumed this cycle stay pending until IDLE takes them.
      wr_pend <= wr_pend | wr_ev;
      rd_pend <= rd_pend | rd_ev;

      case (state)
        IDLE: begin
          if (wr_ev || wr_pend) begin
            wr_pend <= 1'b0;
            state   <= WRITE;
            if (ptr_phase) begin
              ptr       <= i2c_rx_data[ADDR_W-1:0];
              ptr_phase <= 1'b0;
            end else begin
              regs[ptr]   <= i2c_rx_data;
              wr_evt      <= 1'b1;
              wr_evt_addr <= ptr;
`ifdef I2C_REG_AUTOINC_EN
              ptr         <= ptr + ADDR_W'(1);
`endif
            end
          end else if (rd_ev || rd_pend) begin
            rd_pend <= 1'b0;
            state   <= RFETCH;
          end else if (loc_req) begin
            loc_gnt <= 1'b1;
            state   <= LOCAL;
            if (loc_we)
              regs[loc_addr] <= loc_wdata;
            else
              loc_rdata <= regs[loc_addr];
          end
        end
        RFETCH: begin
          i2c_tx_data <= regs[ptr];
          i2c_ready   <= 1'b1;
          ptr_phase   <= 1'b0;
`ifdef I2C_REG_AUTOINC_EN
          ptr         <= ptr + ADDR_W'(1);
`endif
          state       <= RRESP;
        end
        WRITE, RRESP, LOCAL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Testbench for i2c_reg_ctrl: directed sequences plus a randomized mix of
// I2C writes/reads and local accesses, checked against a byte-level model.
module tb_i2c_reg_ctrl;

  localparam int TO = 8192;
`ifdef I2C_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       sys_clk;
  logic       rst;
  logic       i2c_wr;
  logic [7:0] i2c_rx_data;
  logic       i2c_rd;
  logic [7:0] i2c_tx_data;
  logic       i2c_ready;
  logic       loc_req;
  logic       loc_we;
  logic [3:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_gnt;
  logic [7:0] loc_rdata;
  logic       wr_evt;
  logic [3:0] wr_evt_addr;

  i2c_reg_ctrl #(.ADDR_W(4), .TIMEOUT_CYC(TO)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .i2c_wr      (i2c_wr),
    .i2c_rx_data (i2c_rx_data),
    .i2c_rd      (i2c_rd),
    .i2c_tx_data (i2c_tx_data),
    .i2c_ready   (i2c_ready),
    .loc_req     (loc_req),
    .loc_we      (loc_we),
    .loc_addr    (loc_addr),
    .loc_wdata   (loc_wdata),
    .loc_gnt     (loc_gnt),
    .loc_rdata   (loc_rdata),
    .wr_evt      (wr_evt),
    .wr_evt_addr (wr_evt_addr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register file contents, pointer, pointer-phase flag.
  logic [7:0] m_regs [16];
  logic [3:0] m_ptr;
  bit         m_phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr   = 4'h0;
    m_phase = 1'b1;
  endtask

  // Model one written byte; returns whether a wr_evt is expected and where.
  task automatic model_write(input logic [7:0] b, output bit evt, output logic [3:0] addr);
    if (m_phase) begin
      m_ptr   = b[3:0];
      m_phase = 1'b0;
      evt     = 1'b0;
      addr    = 4'h0;
    end else begin
      m_regs[m_ptr] = b;
      evt  = 1'b1;
      addr = m_ptr;
      if (AUTOINC) m_ptr = m_ptr + 4'h1;
    end
  endtask

  task automatic model_read(output logic [7:0] d);
    d       = m_regs[m_ptr];
    m_phase = 1'b0;
    if (AUTOINC) m_ptr = m_ptr + 4'h1;
  endtask

  // All tasks are entered just after a negedge; inputs change there.
  task automatic i2c_write(input logic [7:0] b);
    bit         evt;
    logic [3:0] addr;
    model_write(b, evt, addr);
    i2c_rx_data = b;
    i2c_wr      = 1'b1;
    @(negedge sys_clk);
    check("wr_evt", wr_evt, evt);
    if (evt) check("wr_evt_addr", wr_evt_addr, addr);
    @(negedge sys_clk);
    check("wr_evt_pulse_end", wr_evt, 0);
    i2c_wr = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic i2c_read();
    logic [7:0] d;
    model_read(d);
    i2c_rd = 1'b1;
    @(negedge sys_clk);
    check("ready_not_early", i2c_ready, 0);
    @(negedge sys_clk);
    check("ready_pulse", i2c_ready, 1);
    check("tx_data", i2c_tx_data, d);
    i2c_rd = 1'b0;
    @(negedge sys_clk);
    check("ready_one_cycle", i2c_ready, 0);
    check("tx_data_held", i2c_tx_data, d);
  endtask

  task automatic local_access(input bit we, input logic [3:0] a, input logic [7:0] wd);
    loc_req   = 1'b1;
    loc_we    = we;
    loc_addr  = a;
    loc_wdata = wd;
    @(negedge sys_clk);
    check("loc_gnt", loc_gnt, 1);
    check("loc_no_wr_evt", wr_evt, 0);
    if (!we) check("loc_rdata", loc_rdata, m_regs[a]);
    else     m_regs[a] = wd;
    loc_req = 1'b0;
    @(negedge sys_clk);
    check("loc_gnt_one_cycle", loc_gnt, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit         evt;
    logic [3:0] addr;
    logic [7:0] d;
    logic [7:0] b;

    rst = 1'b1; i2c_wr = 1'b0; i2c_rd = 1'b0; i2c_rx_data = 8'h00;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = 4'h0; loc_wdata = 8'h00;
    model_reset();
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    check("rst_ready", i2c_ready, 0);
    check("rst_tx_data", i2c_tx_data, 0);
    check("rst_loc_gnt", loc_gnt, 0);
    check("rst_loc_rdata", loc_rdata, 0);
    check("rst_wr_evt", wr_evt, 0);
    check("rst_wr_evt_addr", wr_evt_addr, 0);

    // Pointer then two data bytes.
    i2c_write(8'h03);
    i2c_write(8'hAA);
    i2c_write(8'hBB);
    local_access(1'b0, 4'h3, 8'h00);
    local_access(1'b0, 4'h4, 8'h00);

    // Timeout re-arms pointer phase; upper pointer bits are ignored (0xEF -> 15).
    repeat (TO + 20) @(negedge sys_clk);
    m_phase = 1'b1;
    i2c_write(8'hEF);
    i2c_read();
    i2c_read();

    // Gap below the timeout keeps data phase; gap above it restores pointer phase.
    i2c_write(8'h77);
    repeat (TO - 100) @(negedge sys_clk);
    i2c_write(8'h66);
    repeat (TO + 20) @(negedge sys_clk);
    m_phase = 1'b1;
    i2c_write(8'h05);
    i2c_write(8'h11);
    local_access(1'b0, 4'h5, 8'h00);

    // Local write collides with an I2C write edge: I2C first, grant two cycles later.
    model_write(8'h3C, evt, addr);
    i2c_rx_data = 8'h3C; i2c_wr = 1'b1;
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 4'h2; loc_wdata = 8'h5A;
    @(negedge sys_clk);
    check("arb_wr_evt", wr_evt, evt);
    check("arb_gnt_wait0", loc_gnt, 0);
    @(negedge sys_clk);
    check("arb_gnt_wait1", loc_gnt, 0);
    i2c_wr = 1'b0;
    @(negedge sys_clk);
    check("arb_gnt", loc_gnt, 1);
    check("arb_no_wr_evt", wr_evt, 0);
    m_regs[2] = 8'h5A;
    loc_req = 1'b0;
    @(negedge sys_clk);
    check("arb_gnt_end", loc_gnt, 0);
    local_access(1'b0, 4'h2, 8'h00);

    // Simultaneous wr and rd edges: write first, read answered afterwards.
    model_write(8'hC3, evt, addr);
    model_read(d);
    i2c_rx_data = 8'hC3; i2c_wr = 1'b1; i2c_rd = 1'b1;
    @(negedge sys_clk);
    check("both_wr_evt", wr_evt, evt);
    check("both_ready0", i2c_ready, 0);
    @(negedge sys_clk);
    check("both_ready1", i2c_ready, 0);
    i2c_wr = 1'b0;
    @(negedge sys_clk);
    check("both_ready2", i2c_ready, 0);
    @(negedge sys_clk);
    check("both_ready", i2c_ready, 1);
    check("both_tx_data", i2c_tx_data, d);
    i2c_rd = 1'b0;
    @(negedge sys_clk);
    check("both_ready_end", i2c_ready, 0);

    // Randomized mix of accesses.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          b = 8'($urandom);
          i2c_write(b);
        end
        1: i2c_read();
        2: local_access(1'b0, 4'($urandom), 8'h00);
        default: local_access(1'b1, 4'($urandom), 8'($urandom));
      endcase
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
    end
    for (int i = 0; i < 16; i++) local_access(1'b0, 4'(i), 8'h00);

    // Fresh reset, pointer 7 and three data bytes.
    do_reset();
    i2c_write(8'h07);
    i2c_write(8'h01);
    i2c_write(8'h02);
    i2c_write(8'h03);
    local_access(1'b0, 4'h7, 8'h00);
    local_access(1'b0, 4'h8, 8'h00);

    // Reset during RFETCH with rd held: answered after reset with 0x00.
    i2c_rd = 1'b1;
    @(negedge sys_clk);
    check("rfetch_ready0", i2c_ready, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check("rst_hold_ready", i2c_ready, 0);
    end
    rst = 1'b0;
    model_reset();
    model_read(d);
    @(negedge sys_clk);
    check("post_rst_ready0", i2c_ready, 0);
    @(negedge sys_clk);
    check("post_rst_ready", i2c_ready, 1);
    check("post_rst_tx_data", i2c_tx_data, d);
    i2c_rd = 1'b0;
    @(negedge sys_clk);
    check("post_rst_ready_end", i2c_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_reg_ctrl.md
# i2c_reg_ctrl

Byte-level register controller behind the `i2c_slave` block. It turns the slave's `wr`/`rd`/`ready` byte handshake into pointer-addressed accesses to a small internal register file. The same register file is shared with a local on-chip requester (danmaku engine) through a fixed-priority arbiter. It sits between `i2c_slave` and the rest of the FPGA design.

## Interface
- `ADDR_W`, 4: register address width; register file holds 2^ADDR_W bytes.
- `TIMEOUT_CYC`, 8192: idle cycles with no I2C byte event after which the next written byte is treated as a pointer (1..65535).
- `sys_clk`  in  1  system clock (25 MHz); the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `i2c_wr`  in  1  from slave `wr`; level, rising edge = new written byte.
- `i2c_rx_data`  in  8  from slave `data_out`; valid when `i2c_wr` rises.
- `i2c_rd`  in  1  from slave `rd`; level, held by slave until `i2c_ready`.
- `i2c_tx_data`  out  8  to slave `data_in`.
- `i2c_ready`  out  1  to slave `ready`; one-cycle pulse.
- `loc_req`  in  1  local access request, level.
- `loc_we`  in  1  local write when 1, read when 0; sampled with `loc_req`.
- `loc_addr`  in  ADDR_W  local register address.
- `loc_wdata`  in  8  local write data.
- `loc_gnt`  out  1  one-cycle pulse: local access performed.
- `loc_rdata`  out  8  local read data, valid while `loc_gnt`=1.
- `wr_evt`  out  1  one-cycle pulse on every I2C data write committed.
- `wr_evt_addr`  out  ADDR_W  address of that write, valid with `wr_evt`.

## Operation
- Edge detect: `i2c_wr`, `i2c_rd` registered once (`wr_q`, `rd_q`); event = input & !registered copy. The inputs are same-domain, so there is no synchronizer.
- Internal: `ptr` (ADDR_W), `ptr_phase` flag (1 = next written byte is a pointer), idle counter (16 bit, saturating).
- FSM states:
  - `IDLE`:
    - On a wr event, go to `WRITE`.
    - Else on an rd event, go to `RFETCH`.
    - Else if `loc_req`, go to `LOCAL`.
    - Otherwise stay.
  - `WRITE`:
    - If `ptr_phase`: `ptr`<=`i2c_rx_data[ADDR_W-1:0]`, `ptr_phase`<=0.
    - Else: reg[`ptr`]<=`i2c_rx_data`, `wr_evt`=1, `wr_evt_addr`=`ptr`, then `ptr` advances (see Configuration).
    - Next state `IDLE`.
  - `RFETCH`: `i2c_tx_data`<=reg[`ptr`]; advance `ptr`; `ptr_phase`<=0; go to `RRESP`.
  - `RRESP`: `i2c_ready`=1 for exactly this cycle; go to `IDLE`.
  - `LOCAL`:
    - Perform the access at `loc_addr` and pulse `loc_gnt`.
    - On a read, `loc_rdata`=reg[`loc_addr`].
    - On a write, reg[`loc_addr`]<=`loc_wdata`; `wr_evt` is not asserted.
    - Next state `IDLE`.
- Arbitration: I2C events beat `loc_req` in `IDLE`. A local request waits at most one I2C service (2 or 3 cycles). I2C byte events are ≥2000 cycles apart, so there is no starvation.
- An I2C edge arriving while the FSM is not in `IDLE` is latched as pending and serviced on return to `IDLE`. It is never dropped.
- Idle counter:
  - Cleared on every wr/rd event; otherwise increments, saturating.
  - Reaching `TIMEOUT_CYC` sets `ptr_phase`<=1.
- Pointer wraps modulo 2^ADDR_W.
- Pointer bits above ADDR_W in the pointer byte are ignored.
- Reset values:
  - Outputs: `i2c_ready`=0, `i2c_tx_data`=0, `loc_gnt`=0, `loc_rdata`=0, `wr_evt`=0, `wr_evt_addr`=0.
  - Internal: all registers 0, `ptr`=0, `ptr_phase`=1, counter=0, state `IDLE`, pending flags 0.
  - `wr_q`/`rd_q` reset to 0.
- Reset mid-access aborts the access with no register update. If a slave `rd` is pending, it is answered after reset deasserts, because a high `i2c_rd` is seen as a fresh edge.

## Timing
- Write: `i2c_wr` rises at cycle N, the event is detected at N, and reg/`ptr` update plus `wr_evt` occur at N+1.
- Read: `i2c_rd` rises at N, `RFETCH` runs at N+1, and `i2c_tx_data` is valid with `i2c_ready`=1 at N+2. `i2c_tx_data` is held until the next read.
- Local: `loc_req` seen in `IDLE` at N, and `loc_gnt` with `loc_rdata` arrive at N+1. The requester must drop or change `loc_req` the cycle after `loc_gnt`; otherwise a second access is performed.
- Simultaneous wr and rd events: the write is serviced first and the read is held pending.

## Configuration
- `I2C_REG_AUTOINC_EN`:
  - Defined: `ptr` increments by 1 after every I2C data write and every I2C read.
  - Undefined: `ptr` changes only on pointer-byte writes, so repeated accesses hit the same register.

## Test plan
- After reset with `I2C_REG_AUTOINC_EN`, write bytes 0x03, 0xAA, 0xBB over I2C -> reg3=0xAA, reg4=0xBB; `wr_evt` pulses with addr 3 then 4.
- Pointer write 0x0F, then two reads -> `i2c_tx_data` 0x00 then reg0 (wrap); each `i2c_ready` is 1 cycle high, 2 cycles after the `i2c_rd` rise.
- Gap > `TIMEOUT_CYC` after a data write, then write 0x05, 0x11 -> 0x05 taken as pointer, reg5=0x11.
- `loc_req` write (addr 2, 0x5A) in the same cycle as an `i2c_wr` edge -> I2C write first, `loc_gnt` two cycles later, reg2=0x5A, no `wr_evt` for the local write.
- Without the macro: pointer 0x07, then three data writes 0x01, 0x02, 0x03 -> reg7=0x03, reg8 unchanged.
- Assert `rst` during `RFETCH` with `i2c_rd` held high -> no `i2c_ready` during reset; `i2c_ready` pulses 2 cycles after `rst` falls, returning 0x00.
